// File: rtl/leaf_ingress_buffer.sv
// leaf_ingress_buffer
//   Per-leaf ingress stage that sits directly downstream of the cluster hub.
//   Flits addressed to this leaf are buffered in a small first-word-fall-through
//   FIFO and presented to the leaf over valid/ready. A level credit goes back to
//   the hub, and misrouted or overflowing flits are dropped and flagged.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous active-high reset (control state only)
//   in_flit    : flit from the hub leaf output; dest_local in [1:0]
//   in_valid   : one-cycle valid strobe from the hub (no backpressure)
//   out_flit   : head-of-FIFO flit (don't-care while out_valid=0)
//   out_valid  : FIFO non-empty
//   out_ready  : leaf accepts out_flit this cycle
//   cred_out   : level credit to the hub, high while a slot is free
//   occupancy  : current entry count
//   misroute   : sticky, a valid flit arrived for another leaf
//   overflow   : sticky, a valid flit was dropped because the FIFO was full
//   drop_cnt   : saturating count of all dropped flits
//   clr_flags  : synchronous clear of misroute, overflow and drop_cnt
module leaf_ingress_buffer #(
  parameter int         WIDTH   = 20,
  parameter int         DEPTH   = 4,
  parameter logic [1:0] LEAF_ID = 2'd0,
  parameter int         CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_flit,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_flit,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     cred_out,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     misroute,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  logic pop;
  logic push;
  logic match;
  logic full;
  logic drop_mis;
  logic drop_ovf;

  // Saturating increment: holds at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign full      = (count == FULL_CNT);
  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign match     = (in_flit[1:0] == LEAF_ID);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push      = in_valid & match & (~full | pop);
  // Misroute is judged before fullness: a wrong-leaf flit never counts as overflow.
  assign drop_mis  = in_valid & ~match;
  assign drop_ovf  = in_valid & match & full & ~pop;

  assign out_flit  = mem[rd_ptr];
  assign cred_out  = ~full;
  assign occupancy = count;

  // Storage is deliberately not reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  // Pointer and count state; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Sticky flags and drop counter; a drop in a clearing cycle still registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misroute <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clr_flags) begin
      misroute <= drop_mis;
      overflow <= drop_ovf;
      drop_cnt <= (drop_mis | drop_ovf) ? CNT_W'(1) : '0;
    end else begin
      misroute <= misroute | drop_mis;
      overflow <= overflow | drop_ovf;
      if (drop_mis | drop_ovf) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_leaf_ingress_buffer.sv
// Testbench for leaf_ingress_buffer (LEAF_ID=2, DEPTH=4, CNT_W=8).
// Table of directed vectors, hand-written multi-cycle sequences, then random
// traffic against a queue-based reference model.
module tb_leaf_ingress_buffer;

  localparam int WIDTH = 20;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_flit;
  logic             in_valid;
  logic [WIDTH-1:0] out_flit;
  logic             out_valid;
  logic             out_ready;
  logic             cred_out;
  logic [2:0]       occupancy;
  logic             misroute;
  logic             overflow;
  logic [CNT_W-1:0] drop_cnt;
  logic             clr_flags;

  leaf_ingress_buffer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .LEAF_ID(2'd2), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .in_flit(in_flit), .in_valid(in_valid),
    .out_flit(out_flit), .out_valid(out_valid), .out_ready(out_ready),
    .cred_out(cred_out), .occupancy(occupancy), .misroute(misroute),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] mq[$];
  bit m_mis, m_ovf;
  int m_cnt;

  task automatic model_reset();
    mq.delete();
    m_mis = 0; m_ovf = 0; m_cnt = 0;
  endtask

  task automatic model_cycle(input logic iv, input logic [WIDTH-1:0] f,
                             input logic rdy, input logic clr);
    bit was_full, popped, dm, dov;
    was_full = (mq.size() == DEPTH);
    popped   = (mq.size() > 0) && rdy;
    dm = 0; dov = 0;
    if (popped) void'(mq.pop_front());
    if (iv) begin
      if (f[1:0] != 2'd2) dm = 1;
      else if (was_full && !popped) dov = 1;
      else mq.push_back(f);
    end
    if (clr) begin m_mis = 0; m_ovf = 0; m_cnt = 0; end
    if (dm) m_mis = 1;
    if (dov) m_ovf = 1;
    if ((dm || dov) && m_cnt < 255) m_cnt++;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".occ"}, 32'(occupancy), 32'(mq.size()));
    chk({tag, ".vld"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({tag, ".cred"}, 32'(cred_out), 32'(mq.size() < DEPTH));
    chk({tag, ".mis"}, 32'(misroute), 32'(m_mis));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".cnt"}, 32'(drop_cnt), 32'(m_cnt));
    if (mq.size() != 0) chk({tag, ".flit"}, 32'(out_flit), 32'(mq[0]));
  endtask

  task automatic step(input string tag, input logic iv, input logic [WIDTH-1:0] f,
                      input logic rdy, input logic clr);
    in_valid = iv; in_flit = f; out_ready = rdy; clr_flags = clr;
    model_cycle(iv, f, rdy, clr);
    @(posedge clk); #1;
    model_check(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 0; in_flit = '0; out_ready = 0; clr_flags = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] flit;
    logic             rdy;
    logic             clr;
    logic [2:0]       occ;
    logic             vld;
    logic [WIDTH-1:0] head;
    logic             cred;
    logic             mis;
    logic             ovf;
    logic [7:0]       cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic iv, input logic [WIDTH-1:0] f, input logic rdy,
                     input logic clr, input logic [2:0] occ, input logic vld,
                     input logic [WIDTH-1:0] head, input logic cred, input logic mis,
                     input logic ovf, input logic [7:0] cnt);
    vec_t v;
    v.iv = iv; v.flit = f; v.rdy = rdy; v.clr = clr; v.occ = occ; v.vld = vld;
    v.head = head; v.cred = cred; v.mis = mis; v.ovf = ovf; v.cnt = cnt;
    vt.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] f;
    logic iv, rdy, clr;

    rst = 1'b1;
    in_valid = 0; in_flit = '0; out_ready = 0; clr_flags = 0;

    //  iv  flit      rdy clr occ vld head      cred mis ovf cnt
    add(1, 20'h12342, 0, 0, 1, 1, 20'h12342, 1, 0, 0, 0);
    add(1, 20'h0ABC6, 0, 0, 2, 1, 20'h12342, 1, 0, 0, 0);
    add(1, 20'hFFFFE, 0, 0, 3, 1, 20'h12342, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 2, 1, 20'h0ABC6, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 1, 1, 20'hFFFFE, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 0, 0, 20'h00000, 1, 0, 0, 0);
    add(1, 20'h11112, 0, 0, 1, 1, 20'h11112, 1, 0, 0, 0);
    add(1, 20'h22222, 0, 0, 2, 1, 20'h11112, 1, 0, 0, 0);
    add(1, 20'h33332, 0, 0, 3, 1, 20'h11112, 1, 0, 0, 0);
    add(1, 20'h44442, 0, 0, 4, 1, 20'h11112, 0, 0, 0, 0);
    add(1, 20'h55552, 0, 0, 4, 1, 20'h11112, 0, 0, 1, 1);
    add(1, 20'h00003, 0, 0, 4, 1, 20'h11112, 0, 1, 1, 2);
    add(0, 20'h00000, 0, 1, 4, 1, 20'h11112, 0, 0, 0, 0);
    add(1, 20'h66662, 1, 0, 4, 1, 20'h22222, 0, 0, 0, 0);
    add(1, 20'h00001, 0, 1, 4, 1, 20'h22222, 0, 1, 0, 1);
    add(0, 20'h00000, 0, 1, 4, 1, 20'h22222, 0, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 3, 1, 20'h33332, 1, 0, 0, 0);
    add(0, 20'h77773, 0, 0, 3, 1, 20'h33332, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 2, 1, 20'h44442, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 1, 1, 20'h66662, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 0, 0, 20'h00000, 1, 0, 0, 0);
    add(0, 20'h00000, 1, 0, 0, 0, 20'h00000, 1, 0, 0, 0);

    // reset state, while held and after release
    repeat (2) @(posedge clk); #1;
    chk("rst.vld", 32'(out_valid), 0);
    chk("rst.occ", 32'(occupancy), 0);
    chk("rst.cred", 32'(cred_out), 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rel.vld", 32'(out_valid), 0);
    chk("rel.occ", 32'(occupancy), 0);
    chk("rel.cred", 32'(cred_out), 1);
    chk("rel.mis", 32'(misroute), 0);
    chk("rel.ovf", 32'(overflow), 0);
    chk("rel.cnt", 32'(drop_cnt), 0);

    for (int i = 0; i < vt.size(); i++) begin
      in_valid = vt[i].iv; in_flit = vt[i].flit;
      out_ready = vt[i].rdy; clr_flags = vt[i].clr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.occ", i), 32'(occupancy), 32'(vt[i].occ));
      chk($sformatf("vec%0d.vld", i), 32'(out_valid), 32'(vt[i].vld));
      chk($sformatf("vec%0d.cred", i), 32'(cred_out), 32'(vt[i].cred));
      chk($sformatf("vec%0d.mis", i), 32'(misroute), 32'(vt[i].mis));
      chk($sformatf("vec%0d.ovf", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("vec%0d.cnt", i), 32'(drop_cnt), 32'(vt[i].cnt));
      if (vt[i].vld) chk($sformatf("vec%0d.flit", i), 32'(out_flit), 32'(vt[i].head));
    end

    // full FIFO with simultaneous push and pop for 10 cycles, then drain
    do_reset();
    for (int i = 0; i < 4; i++) step("fill", 1, 20'(32'hA0002 + (i << 4)), 0, 0);
    for (int i = 0; i < 10; i++) step("thru", 1, 20'(32'hB0002 + (i << 4)), 1, 0);
    for (int i = 0; i < 5; i++) step("drain", 0, '0, 1, 0);

    // asynchronous reset mid-drain
    do_reset();
    step("pre", 1, 20'h12342, 0, 0);
    step("pre", 1, 20'h0ABC6, 0, 0);
    step("pre", 1, 20'hFFFFE, 0, 0);
    step("pre", 0, '0, 1, 0);
    in_valid = 0; out_ready = 1;
    #3 rst = 1'b1;
    #1;
    chk("arst.vld", 32'(out_valid), 0);
    chk("arst.occ", 32'(occupancy), 0);
    chk("arst.cred", 32'(cred_out), 1);
    model_reset();
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    step("post", 1, 20'hCAFE2, 0, 0);
    step("post", 0, '0, 0, 0);
    step("post", 0, '0, 1, 0);

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) step("sat", 1, 20'h00001, 0, 0);
    chk("sat.final", 32'(drop_cnt), 32'd255);
    step("satclr", 0, '0, 0, 1);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      f = 20'($urandom);
      if ($urandom_range(0, 3) != 0) f[1:0] = 2'd2;
      iv  = ($urandom_range(0, 2) != 0);
      rdy = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 31) == 0);
      step("rand", iv, f, rdy, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
